// File: rtl/led_pkg.sv
// Shared types and helpers for the LED breathing sequencer.
package led_pkg;

    localparam int NUM_LEDS = 4;
    localparam int CH_W     = 2;

    typedef enum logic [2:0] {
        IDLE,
        UP,
        HOLD,
        DOWN,
        NEXT
    } state_t;

    // Result of a channel search: whether a set bit exists, and its index.
    typedef struct packed {
        logic            found;
        logic [CH_W-1:0] idx;
    } ch_sel_t;

    // Lowest set bit of mask. With first=1 the search covers every bit;
    // otherwise only bits strictly above 'from' are considered.
    function automatic ch_sel_t next_set_bit(
        input logic [NUM_LEDS-1:0] mask,
        input logic [CH_W-1:0]     from,
        input logic                first
    );
        ch_sel_t r;
        r = '{found: 1'b0, idx: '0};
        // Scan downwards so the lowest qualifying bit is the last one written.
        for (int i = NUM_LEDS - 1; i >= 0; i--) begin
            if (mask[i] && (first || (i > int'(from)))) begin
                r.found = 1'b1;
                r.idx   = CH_W'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/us_tick_gen.sv
// Microsecond tick prescaler. Counts 0..CLK_PER_US-1 while enabled and
// pulses tick on the terminal count; held at zero while disabled so every
// LED starts its first period with a full-length tick.
module us_tick_gen #(
    parameter int CLK_PER_US = 50
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int               CNT_W = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLK_PER_US - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = en && (cnt == LAST);

    // Prescale counter: clear when idle or on wrap, otherwise count up.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state is assigned with <= so every register samples
        // pre-edge values regardless of statement order.
        if (rst) begin
            cnt <= '0;
        end else if (!en || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/led_breath_seq.sv
// LED breathing sequencer: ramps PWM duty 0->PERIOD, holds for HOLD_PERIODS
// PWM periods, ramps back to 0, then moves to the next enabled LED in
// ascending index order.
// Build option LED_SEQ_LOOP_EN: after the highest enabled LED the sequence
// wraps to the lowest one and runs until stop (done never pulses).
module led_breath_seq
    import led_pkg::*;
#(
    parameter int CLK_PER_US   = 50,
    parameter int PERIOD       = 1000,
    parameter int HOLD_PERIODS = 500
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                stop,
    input  logic [NUM_LEDS-1:0] ch_mask,
    output logic [NUM_LEDS-1:0] pio_led,
    output logic [CH_W-1:0]     cur_ch,
    output logic                busy,
    output logic                done
);

    localparam int PCNT_W = $clog2(PERIOD);
    localparam int DUTY_W = $clog2(PERIOD + 1);
    localparam int HCNT_W = (HOLD_PERIODS > 1) ? $clog2(HOLD_PERIODS) : 1;

    localparam logic [PCNT_W-1:0]   PCNT_LAST = PCNT_W'(PERIOD - 1);
    localparam logic [DUTY_W-1:0]   DUTY_TOP  = DUTY_W'(PERIOD - 1);
    localparam logic [DUTY_W-1:0]   DUTY_ONE  = DUTY_W'(1);
    localparam logic [HCNT_W-1:0]   HCNT_LAST = HCNT_W'(HOLD_PERIODS - 1);
    localparam logic [NUM_LEDS-1:0] LED_ONE   = NUM_LEDS'(1);

    state_t                state;
    state_t                next_state;
    logic [NUM_LEDS-1:0]   mask_q;
    logic [PCNT_W-1:0]     pcnt;
    logic [DUTY_W-1:0]     duty;
    logic [HCNT_W-1:0]     hcnt;
    logic                  pwm;
    logic                  tick;
    logic                  period_end;
    logic                  run;
    logic [CH_W-1:0]       ch_next;
    logic                  done_next;
    ch_sel_t               sel_first;
    ch_sel_t               sel_higher;
`ifdef LED_SEQ_LOOP_EN
    ch_sel_t               sel_wrap;
`endif

    // The prescaler and PWM counters only run while an LED is actively breathing.
    assign run        = (state == UP) || (state == HOLD) || (state == DOWN);
    assign period_end = tick && (pcnt == PCNT_LAST);
    assign busy       = (state != IDLE);
    assign pio_led    = pwm ? (LED_ONE << cur_ch) : '0;

    us_tick_gen #(
        .CLK_PER_US (CLK_PER_US)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (run),
        .tick (tick)
    );

    assign sel_first  = next_set_bit(ch_mask, '0, 1'b1);
    assign sel_higher = next_set_bit(mask_q, cur_ch, 1'b0);
`ifdef LED_SEQ_LOOP_EN
    assign sel_wrap   = next_set_bit(mask_q, '0, 1'b1);
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state, channel selection and done pulse; stop overrides everything.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // can leave one unassigned and infer a latch.
        next_state = state;
        ch_next    = cur_ch;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (start && !stop && sel_first.found) begin
                    next_state = UP;
                    ch_next    = sel_first.idx;
                end
            end
            UP: begin
                if (period_end && (duty == DUTY_TOP)) next_state = HOLD;
            end
            HOLD: begin
                if (period_end && (hcnt == HCNT_LAST)) next_state = DOWN;
            end
            DOWN: begin
                if (period_end && (duty == DUTY_ONE)) next_state = NEXT;
            end
            NEXT: begin
                if (sel_higher.found) begin
                    next_state = UP;
                    ch_next    = sel_higher.idx;
                end else begin
`ifdef LED_SEQ_LOOP_EN
                    next_state = UP;
                    ch_next    = sel_wrap.idx;
`else
                    next_state = IDLE;
                    done_next  = 1'b1;
`endif
                end
            end
            default: next_state = IDLE;
        endcase
        if (stop && (state != IDLE)) begin
            next_state = IDLE;
            ch_next    = cur_ch;
            done_next  = 1'b0;
        end
    end

    // Datapath: mask latch, channel, PWM period counter, duty ramp, hold count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask_q <= '0;
            cur_ch <= '0;
            pcnt   <= '0;
            duty   <= '0;
            hcnt   <= '0;
            pwm    <= 1'b0;
            done   <= 1'b0;
        end else begin
            cur_ch <= ch_next;
            done   <= done_next;
            if ((state == IDLE) && (next_state == UP)) begin
                mask_q <= ch_mask;
            end
            // Outside UP/HOLD/DOWN, or on abort, every LED starts from scratch.
            if (!run || (next_state == IDLE)) begin
                pcnt <= '0;
                duty <= '0;
                hcnt <= '0;
                pwm  <= 1'b0;
            end else begin
                pwm <= (DUTY_W'(pcnt) < duty);
                if (tick) begin
                    pcnt <= (pcnt == PCNT_LAST) ? '0 : pcnt + 1'b1;
                end
                if (period_end) begin
                    case (state)
                        UP:      duty <= duty + 1'b1;
                        HOLD:    hcnt <= hcnt + 1'b1;
                        DOWN:    duty <= duty - 1'b1;
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_led_breath_seq.sv
// Self-checking bench for led_breath_seq. Expected outputs come from a
// cycle-indexed model: time since the accepted start determines which LED
// is active and, from whole PWM periods elapsed, what its duty is.
`timescale 1ns/1ps
module tb_led_breath_seq;

    localparam int CLK_PER_US   = 2;
    localparam int PERIOD       = 4;
    localparam int HOLD_PERIODS = 2;
    localparam int P_CYC        = CLK_PER_US * PERIOD;
    localparam int SEG          = (2 * PERIOD + HOLD_PERIODS) * P_CYC + 1;
`ifdef LED_SEQ_LOOP_EN
    localparam bit LOOP      = 1'b1;
    localparam int EXP_DONES = 0;
`else
    localparam bit LOOP      = 1'b0;
    localparam int EXP_DONES = 1;
`endif

    typedef struct packed {
        logic [3:0] pio;
        logic [1:0] ch;
        logic       busy;
        logic       done;
    } obs_t;

    logic       clk     = 1'b0;
    logic       rst     = 1'b1;
    logic       start   = 1'b0;
    logic       stop    = 1'b0;
    logic [3:0] ch_mask = 4'b0000;
    logic [3:0] pio_led;
    logic [1:0] cur_ch;
    logic       busy;
    logic       done;

    int errors = 0;
    int checks = 0;
    int t      = 0;
    int chans[$];

    led_breath_seq #(
        .CLK_PER_US   (CLK_PER_US),
        .PERIOD       (PERIOD),
        .HOLD_PERIODS (HOLD_PERIODS)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .stop    (stop),
        .ch_mask (ch_mask),
        .pio_led (pio_led),
        .cur_ch  (cur_ch),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Duty after s cycles of an LED's segment: one step per whole PWM period.
    function automatic int duty_at(input int s);
        int n;
        n = s / P_CYC;
        if (n <= PERIOD) return n;
        if (n <= PERIOD + HOLD_PERIODS) return PERIOD;
        return 2 * PERIOD + HOLD_PERIODS - n;
    endfunction

    function automatic int pcnt_at(input int s);
        return (s / CLK_PER_US) % PERIOD;
    endfunction

    // pwm is a register, so it reflects the counters one cycle earlier.
    function automatic bit pwm_at(input int s);
        if (s < 1) return 1'b0;
        return pcnt_at(s - 1) < duty_at(s - 1);
    endfunction

    function automatic obs_t model(input int tt);
        obs_t o;
        int   n, idx, s;
        o   = '0;
        n   = chans.size();
        idx = tt / SEG;
        s   = tt % SEG;
        if (LOOP) idx = idx % n;
        if (idx < n) begin
            o.ch   = 2'(chans[idx]);
            o.busy = 1'b1;
            if (pwm_at(s)) o.pio = 4'(1 << chans[idx]);
        end else begin
            o.ch   = 2'(chans[n - 1]);
            o.done = (tt == n * SEG);
        end
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.pio  = pio_led;
        o.ch   = cur_ch;
        o.busy = busy;
        o.done = done;
        return o;
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("pio=%b ch=%0d busy=%b done=%b", o.pio, o.ch, o.busy, o.done);
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic start_seq(input logic [3:0] m);
        ch_mask = m;
        start   = 1'b1;
        chans.delete();
        for (int i = 0; i < 4; i++) if (m[i]) chans.push_back(i);
        @(posedge clk);
        #1;
        start = 1'b0;
        t     = 0;
    endtask

    task automatic force_idle();
        stop = 1'b1;
        step();
        stop = 1'b0;
        step();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        obs_t got;
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            start   = 1'($urandom);
            stop    = 1'($urandom);
            ch_mask = 4'($urandom);
            step();
            got = sample();
            checks++;
            if (got !== obs_t'(0)) begin
                errors++;
                $display("FAIL reset_hold cyc=%0d got %s expected all zero", k, fmt(got));
            end
        end
        start = 1'b0;
        stop  = 1'b0;
        step();
        rst = 1'b0;
        step();
        got = sample();
        checks++;
        if (got !== obs_t'(0)) begin
            errors++;
            $display("FAIL reset_release got %s expected all zero", fmt(got));
        end
        // Asynchronous reset in the middle of a breathing LED.
        start_seq(4'b1000);
        for (int k = 0; k < 20; k++) step();
        #3;
        rst = 1'b1;
        #1;
        got = sample();
        checks++;
        if (got !== obs_t'(0)) begin
            errors++;
            $display("FAIL reset_async got %s expected all zero", fmt(got));
        end
        step();
        rst = 1'b0;
        step();
        step();
        got = sample();
        checks++;
        if (got !== obs_t'(0)) begin
            errors++;
            $display("FAIL reset_after_async got %s expected all zero", fmt(got));
        end
    endtask

    task automatic test_single_pass();
        obs_t exp, got;
        int   done_cnt, done_t;
        done_cnt = 0;
        done_t   = -1;
        start_seq(4'b0101);
        for (int k = 0; k <= 2 * SEG + 3; k++) begin
            exp = model(t);
            got = sample();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL single_pass t=%0d got %s expected %s", t, fmt(got), fmt(exp));
            end
            if (done) begin
                done_cnt++;
                done_t = t;
            end
            step();
        end
        checks++;
        if (done_cnt !== EXP_DONES) begin
            errors++;
            $display("FAIL single_pass_done_count got %0d expected %0d", done_cnt, EXP_DONES);
        end
`ifndef LED_SEQ_LOOP_EN
        checks++;
        if (done_t !== 2 * SEG) begin
            errors++;
            $display("FAIL single_pass_done_time got %0d expected %0d", done_t, 2 * SEG);
        end
`endif
        force_idle();
    endtask

    task automatic test_duty();
        int high;
        start_seq(4'b0010);
        for (int d = 1; d < PERIOD; d++) begin
            while (t < d * P_CYC + 1) step();
            high = 0;
            for (int k = 0; k < P_CYC; k++) begin
                if (pio_led[cur_ch]) high++;
                step();
            end
            checks++;
            if (high !== d * CLK_PER_US) begin
                errors++;
                $display("FAIL duty_%0d high cycles got %0d expected %0d", d, high, d * CLK_PER_US);
            end
        end
        force_idle();
    endtask

    task automatic test_abort();
        obs_t exp, got;
        int   abort_at;
        abort_at = $urandom_range(PERIOD * P_CYC, (PERIOD + HOLD_PERIODS) * P_CYC - 1);
        start_seq(4'b0101);
        while (t < abort_at) begin
            exp = model(t);
            got = sample();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL abort_pre t=%0d got %s expected %s", t, fmt(got), fmt(exp));
            end
            step();
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({pio_led, busy, done} !== 6'b0) begin
                errors++;
                $display("FAIL abort_idle k=%0d got pio=%b busy=%b done=%b expected 0", k, pio_led, busy, done);
            end
            step();
        end
        start_seq(4'b0000);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({pio_led, busy, done} !== 6'b0) begin
                errors++;
                $display("FAIL empty_mask k=%0d got pio=%b busy=%b done=%b expected 0", k, pio_led, busy, done);
            end
            step();
        end
    endtask

    task automatic test_ignored_ctrl();
        obs_t exp, got;
        start_seq(4'b0101);
        for (int k = 0; k <= 2 * SEG + 2; k++) begin
            exp = model(t);
            got = sample();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL ignored_ctrl t=%0d got %s expected %s", t, fmt(got), fmt(exp));
            end
            start = (t == 10);
            if (t == 10) ch_mask = 4'b1111;
            step();
        end
        start = 1'b0;
        force_idle();
        ch_mask = 4'b1111;
        start   = 1'b1;
        stop    = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({pio_led, busy, done} !== 6'b0) begin
                errors++;
                $display("FAIL start_stop_idle k=%0d got pio=%b busy=%b done=%b expected 0", k, pio_led, busy, done);
            end
            step();
        end
    endtask

    task automatic test_random();
        obs_t exp, got;
        int   n, len, abort_at;
        for (int it = 0; it < 4; it++) begin
            start_seq(4'($urandom_range(1, 15)));
            n        = chans.size();
            len      = LOOP ? 2 * n * SEG : n * SEG + 2;
            abort_at = ($urandom_range(0, 1) == 1) ? $urandom_range(0, n * SEG - 1) : -1;
            for (int k = 0; k <= len; k++) begin
                exp = model(t);
                got = sample();
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL random it=%0d t=%0d got %s expected %s", it, t, fmt(got), fmt(exp));
                end
                ch_mask = 4'($urandom);
                start   = (LOOP || t < n * SEG) && ($urandom_range(0, 15) == 0);
                stop    = (t == abort_at);
                step();
                if (stop) begin
                    stop  = 1'b0;
                    start = 1'b0;
                    checks++;
                    if ({pio_led, busy, done} !== 6'b0) begin
                        errors++;
                        $display("FAIL random_abort it=%0d got pio=%b busy=%b done=%b expected 0", it, pio_led, busy, done);
                    end
                    break;
                end
            end
            start = 1'b0;
            force_idle();
        end
    endtask

`ifdef LED_SEQ_LOOP_EN
    task automatic test_loop();
        obs_t exp, got;
        start_seq(4'b1000);
        for (int k = 0; k < 3 * SEG + 2; k++) begin
            exp = model(t);
            got = sample();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL loop t=%0d got %s expected %s", t, fmt(got), fmt(exp));
            end
            step();
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        checks++;
        if ({pio_led, busy, done} !== 6'b0) begin
            errors++;
            $display("FAIL loop_stop got pio=%b busy=%b done=%b expected 0", pio_led, busy, done);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_pass();
        test_duty();
        test_abort();
        test_ignored_ctrl();
        test_random();
`ifdef LED_SEQ_LOOP_EN
        test_loop();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
